// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter; build option WB_MEM_PRIORITY_EN.
// Pure declarations: no latency, no backpressure.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester channels, regfile write port and hazard status of the arbiter.
// Ready depends only on FIFO occupancy; the write port is driven combinationally from FIFO heads.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [31:0]       pending;
  logic              idle;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, RegWrite, WriteRegister, WriteData, pending, idle
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, RegWrite, WriteRegister, WriteData, pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// DEPTH-entry synchronous FIFO of writeback requests; head is visible the cycle after a push.
// full blocks pushes even when a pop happens in the same cycle; contents are exported for hazard decode.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                din,
  output logic                   full,
  output logic                   empty,
  output wb_req_t                head,
  output logic [DEPTH-1:0]       entry_valid,
  output wb_req_t [DEPTH-1:0]    entries
);
  localparam int PW = $clog2(DEPTH);

  wb_req_t [DEPTH-1:0] mem;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         cnt;
  logic                do_push;
  logic                do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < cnt);
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load writebacks via two FIFOs and an arbiter (WB_MEM_PRIORITY_EN: fixed MEM priority).
// Accept at edge E, write at edge E+1 at best; ready = FIFO not full, writes to x31 are accepted and dropped.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  wb_req_t             alu_din, mem_din, alu_head, mem_head, gnt_head;
  wb_req_t [DEPTH-1:0] alu_ent, mem_ent;
  logic [DEPTH-1:0]    alu_ev, mem_ev;
  logic                alu_full, alu_empty, mem_full, mem_empty;
  logic                alu_push, mem_push, alu_pop, mem_pop;
  logic                wr_en;
  grant_t              gnt;

  assign alu_din.addr = REG_ADDR_W'(bus.alu_addr);
  assign alu_din.data = REG_DATA_W'(bus.alu_data);
  assign mem_din.addr = REG_ADDR_W'(bus.mem_addr);
  assign mem_din.data = REG_DATA_W'(bus.mem_data);

  assign bus.alu_ready = !alu_full && !reset;
  assign bus.mem_ready = !mem_full && !reset;
  assign alu_push = bus.alu_valid && bus.alu_ready && (alu_din.addr != ZERO_REG);
  assign mem_push = bus.mem_valid && bus.mem_ready && (mem_din.addr != ZERO_REG);

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .reset(reset), .push(alu_push), .pop(alu_pop), .din(alu_din),
    .full(alu_full), .empty(alu_empty), .head(alu_head),
    .entry_valid(alu_ev), .entries(alu_ent)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk(clk), .reset(reset), .push(mem_push), .pop(mem_pop), .din(mem_din),
    .full(mem_full), .empty(mem_empty), .head(mem_head),
    .entry_valid(mem_ev), .entries(mem_ent)
  );

`ifdef WB_MEM_PRIORITY_EN
  // Loads sit on the critical path, so they win every contention.
  always_comb begin
    gnt = mem_empty ? GNT_ALU : GNT_MEM;
  end
`else
  grant_t last_grant, last_grant_nxt;

  always_ff @(posedge clk) begin
    if (reset) last_grant <= GNT_MEM;
    else       last_grant <= last_grant_nxt;
  end

  always_comb begin
    last_grant_nxt = last_grant;
    if (wr_en) last_grant_nxt = gnt;
  end

  always_comb begin
    gnt = GNT_ALU;
    if (!alu_empty && !mem_empty) gnt = (last_grant == GNT_MEM) ? GNT_ALU : GNT_MEM;
    else if (!mem_empty)          gnt = GNT_MEM;
  end
`endif

  assign wr_en    = (!alu_empty || !mem_empty) && !reset;
  assign alu_pop  = wr_en && (gnt == GNT_ALU);
  assign mem_pop  = wr_en && (gnt == GNT_MEM);
  assign gnt_head = (gnt == GNT_MEM) ? mem_head : alu_head;

  assign bus.RegWrite      = wr_en;
  assign bus.WriteRegister = wr_en ? ADDR_W'(gnt_head.addr) : '0;
  assign bus.WriteData     = wr_en ? DATA_W'(gnt_head.data) : '0;
  assign bus.idle          = alu_empty && mem_empty;

  // Entries stay visible through their pop cycle; x31 never enters a FIFO.
  always_comb begin
    bus.pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_ev[i]) bus.pending[alu_ent[i].addr] = 1'b1;
      if (mem_ev[i]) bus.pending[mem_ent[i].addr] = 1'b1;
    end
    bus.pending[ZERO_REG] = 1'b0;
    if (reset) bus.pending = '0;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: fixed vector table, directed multi-cycle sequences, random traffic vs a queue model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [63:0] md;
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [31:0] pend;
    logic        idle;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(64)) bus ();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  ent_t mq_alu[$], mq_mem[$];
  ent_t src_alu[$], src_mem[$];
  int   m_last = 1;
  logic [4:0] wr_log[$];
  int   wr_cyc[$];
  bit   saw_block = 0;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
  endtask

  task automatic model_clear();
    mq_alu.delete(); mq_mem.delete();
    m_last = 1;
  endtask

  // Called at the negedge: compare DUT against the queue model, then advance both across the edge.
  task automatic step(output bit a_hs, output bit m_hs);
    logic e_rw, e_ar, e_mr, e_idle;
    logic [4:0] e_wr;
    logic [63:0] e_wd;
    logic [31:0] e_p;
    int g;
    e_rw = (mq_alu.size() != 0) || (mq_mem.size() != 0);
`ifdef WB_MEM_PRIORITY_EN
    g = (mq_mem.size() != 0) ? 1 : 0;
`else
    if (mq_alu.size() != 0 && mq_mem.size() != 0) g = (m_last == 1) ? 0 : 1;
    else g = (mq_mem.size() != 0) ? 1 : 0;
`endif
    e_wr = '0; e_wd = '0;
    if (e_rw) begin
      e_wr = (g == 0) ? mq_alu[0].a : mq_mem[0].a;
      e_wd = (g == 0) ? mq_alu[0].d : mq_mem[0].d;
    end
    e_p = '0;
    foreach (mq_alu[i]) e_p[mq_alu[i].a] = 1'b1;
    foreach (mq_mem[i]) e_p[mq_mem[i].a] = 1'b1;
    e_ar = mq_alu.size() < DEPTH;
    e_mr = mq_mem.size() < DEPTH;
    e_idle = !e_rw;
    vectors++;
    if (bus.RegWrite !== e_rw || (e_rw && (bus.WriteRegister !== e_wr || bus.WriteData !== e_wd)) ||
        bus.pending !== e_p || bus.alu_ready !== e_ar || bus.mem_ready !== e_mr || bus.idle !== e_idle) begin
      miscompares++;
      $display("FAIL model cyc %0d: RegWrite %0b/%0b WR %0d/%0d WD %0h/%0h pend %h/%h rdy %b%b/%b%b idle %0b/%0b",
               cyc, bus.RegWrite, e_rw, bus.WriteRegister, e_wr, bus.WriteData, e_wd,
               bus.pending, e_p, bus.alu_ready, bus.mem_ready, e_ar, e_mr, bus.idle, e_idle);
    end
    if (bus.RegWrite === 1'b1) begin
      wr_log.push_back(bus.WriteRegister);
      wr_cyc.push_back(cyc);
    end
    if ((bus.alu_valid && !bus.alu_ready) || (bus.mem_valid && !bus.mem_ready)) saw_block = 1;
    a_hs = bus.alu_valid && (bus.alu_ready === 1'b1);
    m_hs = bus.mem_valid && (bus.mem_ready === 1'b1);
    if (e_rw) begin
      if (g == 0) void'(mq_alu.pop_front());
      else        void'(mq_mem.pop_front());
      m_last = g;
    end
    if (a_hs && bus.alu_addr != 5'd31) mq_alu.push_back('{a: bus.alu_addr, d: bus.alu_data});
    if (m_hs && bus.mem_addr != 5'd31) mq_mem.push_back('{a: bus.mem_addr, d: bus.mem_data});
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  // Drive src_alu/src_mem, holding each request until accepted; bounded by budget cycles.
  task automatic run_streams(input bit gaps, input int budget);
    bit a_on = 0, m_on = 0, ah, mh;
    int n = 0;
    while ((src_alu.size() != 0 || src_mem.size() != 0 || mq_alu.size() != 0 || mq_mem.size() != 0) && n < budget) begin
      if (!a_on && src_alu.size() != 0) a_on = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!m_on && src_mem.size() != 0) m_on = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.alu_valid = a_on;
      bus.alu_addr  = a_on ? src_alu[0].a : 5'd0;
      bus.alu_data  = a_on ? src_alu[0].d : 64'd0;
      bus.mem_valid = m_on;
      bus.mem_addr  = m_on ? src_mem[0].a : 5'd0;
      bus.mem_data  = m_on ? src_mem[0].d : 64'd0;
      @(negedge clk);
      step(ah, mh);
      if (ah) begin void'(src_alu.pop_front()); a_on = 0; end
      if (mh) begin void'(src_mem.pop_front()); m_on = 0; end
      n++;
    end
    idle_inputs();
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL stream_timeout: got %0d cycles, required under %0d", n, budget);
    end
  endtask

  initial begin
    bit ah, mh;
    int s, nlog;
    logic [4:0] exp_cont[8];

    tbl[0] = '{1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1};
    tbl[1] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hDEAD_BEEF, 32'h20, 1'b0};
    tbl[2] = '{1'b1, 5'd31, 64'h1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 5'd7, 64'd7, 1'b1, 5'd9, 64'd9, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'd9, 32'h280, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd7, 32'h80, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 32'h0, 1'b1};

    // Reset state
    idle_inputs();
    reset = 1;
    @(negedge clk);
    chk("reset_regwrite", {63'd0, bus.RegWrite}, 64'd0);
    chk("reset_pending", {32'd0, bus.pending}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    model_clear();
    @(negedge clk);
    chk("post_reset_idle", {63'd0, bus.idle}, 64'd1);
    chk("post_reset_ready", {62'd0, bus.alu_ready, bus.mem_ready}, 64'd3);
    step(ah, mh);

    // Table: single write, x31 drop, two-channel pair
    for (int i = 0; i < 8; i++) begin
      bus.alu_valid = tbl[i].av; bus.alu_addr = tbl[i].aa; bus.alu_data = tbl[i].ad;
      bus.mem_valid = tbl[i].mv; bus.mem_addr = tbl[i].ma; bus.mem_data = tbl[i].md;
      @(negedge clk);
      vectors++;
      if (bus.RegWrite !== tbl[i].rw || (tbl[i].rw && (bus.WriteRegister !== tbl[i].wr || bus.WriteData !== tbl[i].wd)) ||
          bus.pending !== tbl[i].pend || bus.idle !== tbl[i].idle || bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL table[%0d]: RegWrite %0b/%0b WR %0d/%0d WD %0h/%0h pend %h/%h idle %0b/%0b rdy %b%b/11",
                 i, bus.RegWrite, tbl[i].rw, bus.WriteRegister, tbl[i].wr, bus.WriteData, tbl[i].wd,
                 bus.pending, tbl[i].pend, bus.idle, tbl[i].idle, bus.alu_ready, bus.mem_ready);
      end
      step(ah, mh);
    end
    idle_inputs();

    // Contention with backpressure
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      src_alu.push_back('{a: 5'(i), d: 64'(i)});
      src_mem.push_back('{a: 5'(i + 10), d: 64'(i + 10)});
    end
`ifdef WB_MEM_PRIORITY_EN
    exp_cont = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd1, 5'd2, 5'd3, 5'd4};
`else
    exp_cont = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
`endif
    wr_log.delete(); wr_cyc.delete(); saw_block = 0;
    run_streams(1'b0, 100);
    chk("contention_count", 64'(wr_log.size()), 64'd8);
    if (wr_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk($sformatf("contention_order[%0d]", i), 64'(wr_log[i]), 64'(exp_cont[i]));
      chk("contention_back_to_back", 64'(wr_cyc[7] - wr_cyc[0]), 64'd7);
    end
    chk("backpressure_seen", {63'd0, saw_block}, 64'd1);

    // Reset mid-operation
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      bus.alu_valid = 1; bus.alu_addr = 5'(20 + 2 * i); bus.alu_data = 64'(100 + i);
      bus.mem_valid = 1; bus.mem_addr = 5'(21 + 2 * i); bus.mem_data = 64'(200 + i);
      @(negedge clk);
      step(ah, mh);
    end
    idle_inputs();
    reset = 1;
    nlog = wr_log.size();
    @(negedge clk);
    chk("midreset_regwrite", {63'd0, bus.RegWrite}, 64'd0);
    chk("midreset_pending", {32'd0, bus.pending}, 64'd0);
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    @(negedge clk);
    chk("after_reset_idle", {63'd0, bus.idle}, 64'd1);
    chk("after_reset_ready", {62'd0, bus.alu_ready, bus.mem_ready}, 64'd3);
    chk("after_reset_pending", {32'd0, bus.pending}, 64'd0);
    step(ah, mh);
    @(negedge clk);
    step(ah, mh);
    chk("after_reset_no_write", 64'(wr_log.size()), 64'(nlog));

    // Wrap: 10 back-to-back ALU writes
    reset_dut();
    for (int i = 0; i < 10; i++) src_alu.push_back('{a: 5'(i), d: 64'(i)});
    wr_log.delete(); wr_cyc.delete();
    s = cyc;
    run_streams(1'b0, 100);
    chk("wrap_count", 64'(wr_log.size()), 64'd10);
    if (wr_log.size() == 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("wrap_order[%0d]", i), 64'(wr_log[i]), 64'(i));
      chk("wrap_first_latency", 64'(wr_cyc[0] - s), 64'd1);
      chk("wrap_no_bubble", 64'(wr_cyc[9] - wr_cyc[0]), 64'd9);
    end

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      src_alu.push_back('{a: 5'($urandom_range(0, 31)), d: {$urandom, $urandom}});
      src_mem.push_back('{a: 5'($urandom_range(0, 31)), d: {$urandom, $urandom}});
    end
    run_streams(1'b1, 5000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
